// File: rtl/sensor_stream_pkg.sv
// ============================================================================
// Module   : sensor_stream_pkg
// Brief    : Shared state encoding, pattern-select codes and LFSR helper for
//            the sensor stream generator.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sensor_stream_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEAD   = 3'd1;
    localparam logic [2:0] ST_ACT    = 3'd2;
    localparam logic [2:0] ST_HIDE   = 3'd3;
    localparam logic [2:0] ST_TAIL   = 3'd4;
    localparam logic [2:0] ST_VBLANK = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LEAD   = ST_LEAD,
        ACT    = ST_ACT,
        HIDE   = ST_HIDE,
        TAIL   = ST_TAIL,
        VBLANK = ST_VBLANK
    } state_t;

    localparam logic [1:0] PAT_LINE_INC  = 2'b00;
    localparam logic [1:0] PAT_FRAME_INC = 2'b01;
    localparam logic [1:0] PAT_PIX_INC   = 2'b10;
    localparam logic [1:0] PAT_RANDOM    = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'h0001;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_pattern_gen.sv
// ============================================================================
// Module   : sensor_pattern_gen
// Brief    : Registered per-channel test-pattern datapath; zero outside active
//            beats. SENSOR_STREAM_GEN_RANDOM_EN adds per-channel LFSRs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sensor_pattern_gen
    import sensor_stream_pkg::*;
#(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int REG_WD           = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_en,
    input  logic [REG_WD-1:0]                     i_line,
    input  logic [REG_WD-1:0]                     i_beat,
    input  logic [15:0]                           i_frame_cnt,
    input  logic [1:0]                            i_pat,
    output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] o_pix_data
);

    logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] w_pix;
    logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] r_pix;

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_chan
        logic [REG_WD-1:0]           w_idx;
        logic [SENSOR_DAT_WIDTH-1:0] w_val;

        assign w_idx = i_beat * REG_WD'(CHANNEL_NUM) + REG_WD'(c);

`ifdef SENSOR_STREAM_GEN_RANDOM_EN
        logic [15:0] r_lfsr;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_lfsr <= LFSR_SEED;
            end else if (i_en) begin
                r_lfsr <= lfsr16_next(r_lfsr);
            end
        end
`endif

        always_comb begin
            w_val = SENSOR_DAT_WIDTH'(w_idx);
            case (i_pat)
                PAT_LINE_INC:  w_val = SENSOR_DAT_WIDTH'(i_line);
                PAT_FRAME_INC: w_val = SENSOR_DAT_WIDTH'(i_frame_cnt);
`ifdef SENSOR_STREAM_GEN_RANDOM_EN
                PAT_RANDOM:    w_val = SENSOR_DAT_WIDTH'(r_lfsr);
`endif
                // Without the random option, pattern 11 falls back to pixel-increment
                default:       w_val = SENSOR_DAT_WIDTH'(w_idx);
            endcase
        end

        assign w_pix[c*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH] = w_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix <= '0;
        end else begin
            r_pix <= i_en ? w_pix : '0;
        end
    end

    assign o_pix_data = r_pix;

endmodule

`default_nettype wire

// File: rtl/sensor_stream_gen.sv
// ============================================================================
// Module   : sensor_stream_gen
// Brief    : Camera-sensor style fval/lval/pixel stream generator with latched
//            per-frame timing. Optional macro: SENSOR_STREAM_GEN_RANDOM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sensor_stream_gen
    import sensor_stream_pkg::*;
#(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int REG_WD           = 32,
    parameter int FVAL_LVAL_GAP    = 3
) (
    input  logic                                    clk_sensor_pix,
    input  logic                                    reset_sensor,
    input  logic                                    i_stream_enable,
    input  logic [REG_WD-1:0]                       iv_line_active_pix,
    input  logic [REG_WD-1:0]                       iv_line_hide_pix,
    input  logic [REG_WD-1:0]                       iv_frame_active_line,
    input  logic [REG_WD-1:0]                       iv_frame_hide_line,
    input  logic [1:0]                              iv_pattern_sel,
    output logic                                    o_fval,
    output logic                                    o_lval,
    output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic [15:0]                             ov_frame_cnt
);

    localparam logic [REG_WD-1:0] c_one      = REG_WD'(1);
    localparam logic [REG_WD-1:0] c_gap_last =
        (FVAL_LVAL_GAP > 1) ? REG_WD'(FVAL_LVAL_GAP - 1) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [REG_WD-1:0] r_cnt;
    logic [REG_WD-1:0] w_cnt_nxt;
    logic [REG_WD-1:0] r_line;
    logic [REG_WD-1:0] w_line_nxt;
    logic [REG_WD-1:0] r_act_pix;
    logic [REG_WD-1:0] r_hide_pix;
    logic [REG_WD-1:0] r_act_line;
    logic [REG_WD-1:0] r_vblank;
    logic [1:0]        r_pat;
    logic              r_fval;
    logic              r_lval;
    logic [15:0]       r_frame_cnt;
    logic              w_enter_lead;
    logic              w_frame_done;
    logic              w_act_nxt;

    function automatic logic [REG_WD-1:0] f_nz(input logic [REG_WD-1:0] v);
        return (v == '0) ? c_one : v;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (i_stream_enable) w_state_nxt = LEAD;
            LEAD:   if (r_cnt == c_gap_last) w_state_nxt = ACT;
            ACT:    if (r_cnt == r_act_pix - c_one)
                        w_state_nxt = (r_line == r_act_line - c_one) ? TAIL : HIDE;
            HIDE:   if (r_cnt == r_hide_pix - c_one) w_state_nxt = ACT;
            TAIL:   if (r_cnt == c_gap_last) w_state_nxt = VBLANK;
            VBLANK: if (r_cnt == r_vblank - c_one)
                        w_state_nxt = i_stream_enable ? LEAD : IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_cnt_nxt = ((w_state_nxt == r_state) && (r_state != IDLE)) ? r_cnt + c_one : '0;

        w_line_nxt = r_line;
        if (w_state_nxt == LEAD) begin
            w_line_nxt = '0;
        end else if ((r_state == HIDE) && (w_state_nxt == ACT)) begin
            w_line_nxt = r_line + c_one;
        end

        w_enter_lead = (w_state_nxt == LEAD) && (r_state != LEAD);
        w_frame_done = (r_state == TAIL) && (w_state_nxt == VBLANK);
        w_act_nxt    = (w_state_nxt == ACT);
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk_sensor_pix) begin
        if (reset_sensor) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_act_pix   <= '0;
            r_hide_pix  <= '0;
            r_act_line  <= '0;
            r_vblank    <= '0;
            r_pat       <= PAT_LINE_INC;
            r_fval      <= 1'b0;
            r_lval      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
            if (w_enter_lead) begin
                r_act_pix  <= f_nz(iv_line_active_pix);
                r_hide_pix <= f_nz(iv_line_hide_pix);
                r_act_line <= f_nz(iv_frame_active_line);
                r_vblank   <= f_nz(iv_frame_hide_line);
                r_pat      <= iv_pattern_sel;
            end
            r_fval <= (w_state_nxt != IDLE) && (w_state_nxt != VBLANK);
            r_lval <= w_act_nxt;
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    sensor_pattern_gen #(
        .SENSOR_DAT_WIDTH (SENSOR_DAT_WIDTH),
        .CHANNEL_NUM      (CHANNEL_NUM),
        .REG_WD           (REG_WD)
    ) u_pattern (
        .clk         (clk_sensor_pix),
        .rst         (reset_sensor),
        .i_en        (w_act_nxt),
        .i_line      (w_line_nxt),
        .i_beat      (w_cnt_nxt),
        .i_frame_cnt (r_frame_cnt),
        .i_pat       (r_pat),
        .o_pix_data  (ov_pix_data)
    );

    assign o_fval       = r_fval;
    assign o_lval       = r_lval;
    assign ov_frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sensor_stream_gen.sv
// ============================================================================
// Module   : tb_sensor_stream_gen
// Brief    : Self-checking bench for sensor_stream_gen against a frame-trace
//            model. Honours SENSOR_STREAM_GEN_RANDOM_EN for pattern 11.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sensor_stream_gen;

    localparam int W   = 10;
    localparam int CH  = 4;
    localparam int RW  = 32;
    localparam int GAP = 3;

    logic              clk = 1'b0;
    logic              reset_sensor;
    logic              enable;
    logic [RW-1:0]     act_pix, hide_pix, act_line, hide_line;
    logic [1:0]        pat;
    logic              fval, lval;
    logic [W*CH-1:0]   pix;
    logic [15:0]       fcnt;

    always #5 clk = ~clk;

    sensor_stream_gen #(
        .SENSOR_DAT_WIDTH (W),
        .CHANNEL_NUM      (CH),
        .REG_WD           (RW),
        .FVAL_LVAL_GAP    (GAP)
    ) dut (
        .clk_sensor_pix       (clk),
        .reset_sensor         (reset_sensor),
        .i_stream_enable      (enable),
        .iv_line_active_pix   (act_pix),
        .iv_line_hide_pix     (hide_pix),
        .iv_frame_active_line (act_line),
        .iv_frame_hide_line   (hide_line),
        .iv_pattern_sel       (pat),
        .o_fval               (fval),
        .o_lval               (lval),
        .ov_pix_data          (pix),
        .ov_frame_cnt         (fcnt)
    );

    typedef struct packed {
        logic            fval;
        logic            lval;
        logic [W*CH-1:0] data;
        logic [15:0]     fcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] m_fcnt;
    logic [15:0] m_lfsr [CH];

    function automatic int nz(input logic [RW-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    task automatic push(input logic f, input logic l, input logic [W*CH-1:0] d);
        exp_t e;
        e.fval = f; e.lval = l; e.data = d; e.fcnt = m_fcnt;
        exp_q.push_back(e);
    endtask

    function automatic logic [W*CH-1:0] beat_data(input int p, input int line, input int beat);
        logic [W*CH-1:0] d;
        logic [31:0]     v;
        d = '0;
        for (int c = 0; c < CH; c++) begin
            case (p)
                0: v = line;
                1: v = {16'd0, m_fcnt};
`ifdef SENSOR_STREAM_GEN_RANDOM_EN
                3: v = {16'd0, m_lfsr[c]};
`endif
                default: v = beat * CH + c;
            endcase
            d[c*W +: W] = v[W-1:0];
        end
        return d;
    endfunction

    task automatic model_reset();
        m_fcnt = 16'd0;
        for (int c = 0; c < CH; c++) m_lfsr[c] = 16'h0001;
        exp_q.delete();
    endtask

    // Expected per-clock trace of one whole frame, starting at the first lead clock
    task automatic build_frame(input logic [RW-1:0] a, input logic [RW-1:0] h,
                               input logic [RW-1:0] n, input logic [RW-1:0] vb,
                               input logic [1:0] p);
        int na, nh, nn, nv;
        na = nz(a); nh = nz(h); nn = nz(n); nv = nz(vb);
        repeat (GAP) push(1'b1, 1'b0, '0);
        for (int l = 0; l < nn; l++) begin
            for (int b = 0; b < na; b++) begin
                push(1'b1, 1'b1, beat_data(int'(p), l, b));
                for (int c = 0; c < CH; c++)
                    m_lfsr[c] = {m_lfsr[c][14:0],
                                 m_lfsr[c][15] ^ m_lfsr[c][13] ^ m_lfsr[c][12] ^ m_lfsr[c][10]};
            end
            if (l < nn - 1) repeat (nh) push(1'b1, 1'b0, '0);
        end
        repeat (GAP) push(1'b1, 1'b0, '0);
        m_fcnt = m_fcnt + 16'd1;
        repeat (nv) push(1'b0, 1'b0, '0);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        reset_sensor = 1'b1;
        enable = 1'b0;
        act_pix = $urandom_range(0, 20); hide_pix = $urandom_range(0, 20);
        act_line = $urandom_range(0, 20); hide_line = $urandom_range(0, 20);
        pat = 2'($urandom_range(0, 3));
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({fval, lval, pix, fcnt} !== 58'd0) begin
            errors++;
            $display("FAIL reset_state: got fval=%b lval=%b data=%h fcnt=%0d, want all zero",
                     fval, lval, pix, fcnt);
        end
        reset_sensor = 1'b0;
        model_reset();
        push_idle(4);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({fval, lval, pix, fcnt} !== e) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                         i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
            end
        end
    endtask

    task automatic test_basic_frame();
        exp_t e;
        int   n, fv_cnt, lv_pulses, beat, first_f, first_l;
        logic prev_l;
        act_pix = 8; hide_pix = 4; act_line = 3; hide_line = 10; pat = 2'b10;
        enable = 1'b1;
        build_frame(act_pix, hide_pix, act_line, hide_line, pat);
        push_idle(3);
        n = exp_q.size();
        fv_cnt = 0; lv_pulses = 0; beat = 0; prev_l = 1'b0; first_f = -1; first_l = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({fval, lval, pix, fcnt} !== e) begin
                errors++;
                $display("FAIL basic_frame cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                         i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
            end
            if (fval) begin
                fv_cnt++;
                if (first_f < 0) first_f = i;
            end
            if (lval && !prev_l) begin
                lv_pulses++;
                beat = 0;
                if (first_l < 0) first_l = i;
            end
            if (lval && beat == 0) begin
                vectors++;
                if (pix !== {10'd3, 10'd2, 10'd1, 10'd0}) begin
                    errors++;
                    $display("FAIL first_beat cyc %0d: got %h want %h", i, pix,
                             {10'd3, 10'd2, 10'd1, 10'd0});
                end
            end
            if (lval && beat == 1) begin
                vectors++;
                if (pix !== {10'd7, 10'd6, 10'd5, 10'd4}) begin
                    errors++;
                    $display("FAIL second_beat cyc %0d: got %h want %h", i, pix,
                             {10'd7, 10'd6, 10'd5, 10'd4});
                end
            end
            if (lval) beat++;
            prev_l = lval;
            if (i == 5) enable = 1'b0;
        end
        vectors++;
        if (fv_cnt != 38) begin
            errors++;
            $display("FAIL fval_length: got %0d clocks want 38", fv_cnt);
        end
        vectors++;
        if (lv_pulses != 3) begin
            errors++;
            $display("FAIL lval_pulses: got %0d want 3", lv_pulses);
        end
        vectors++;
        if (first_l - first_f != GAP) begin
            errors++;
            $display("FAIL fval_to_lval: got %0d clocks want %0d", first_l - first_f, GAP);
        end
    endtask

    task automatic test_random_frames();
        exp_t e;
        int   n;
        for (int k = 0; k < 6; k++) begin
            act_pix = $urandom_range(0, 6); hide_pix = $urandom_range(0, 4);
            act_line = $urandom_range(0, 4); hide_line = $urandom_range(0, 5);
            pat = 2'($urandom_range(0, 3));
            enable = 1'b1;
            build_frame(act_pix, hide_pix, act_line, hide_line, pat);
            push_idle($urandom_range(1, 3));
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if ({fval, lval, pix, fcnt} !== e) begin
                    errors++;
                    $display("FAIL random_frame %0d cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                             k, i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
                end
                if (i == 0) enable = 1'b0;
                if (i == 1) begin
                    act_pix = $urandom_range(0, 50); hide_pix = $urandom_range(0, 50);
                    act_line = $urandom_range(0, 50); hide_line = $urandom_range(0, 50);
                    pat = 2'($urandom_range(0, 3));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n, len1;
        act_pix = 8; hide_pix = 4; act_line = 3; hide_line = 10; pat = 2'b10;
        enable = 1'b1;
        build_frame(8, 4, 3, 10, 2'b10);
        len1 = exp_q.size();
        build_frame(16, 4, 3, 10, 2'b00);
        push_idle(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({fval, lval, pix, fcnt} !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                         i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
            end
            if (i == GAP + 8 + 4 + 2) begin
                act_pix = 16;
                pat = 2'b00;
            end
            if (i == len1) enable = 1'b0;
        end
    endtask

    task automatic test_zero_regs();
        exp_t e;
        int   n, fv_cnt;
        act_pix = 0; hide_pix = 0; act_line = 0; hide_line = 0; pat = 2'b10;
        enable = 1'b1;
        build_frame(0, 0, 0, 0, 2'b10);
        push_idle(2);
        n = exp_q.size();
        fv_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({fval, lval, pix, fcnt} !== e) begin
                errors++;
                $display("FAIL zero_regs cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                         i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
            end
            if (fval) fv_cnt++;
            if (i == 0) enable = 1'b0;
        end
        vectors++;
        if (fv_cnt != 7) begin
            errors++;
            $display("FAIL zero_regs_fval_length: got %0d clocks want 7", fv_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int   n;
        act_pix = 8; hide_pix = 4; act_line = 3; hide_line = 10; pat = 2'b01;
        enable = 1'b1;
        build_frame(act_pix, hide_pix, act_line, hide_line, pat);
        for (int i = 0; i < GAP + 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({fval, lval, pix, fcnt} !== e) begin
                errors++;
                $display("FAIL pre_reset cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                         i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
            end
        end
        reset_sensor = 1'b1;
        @(negedge clk);
        vectors++;
        if ({fval, lval, pix, fcnt} !== 58'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: got fval=%b lval=%b data=%h fcnt=%0d, want all zero",
                     fval, lval, pix, fcnt);
        end
        model_reset();
        reset_sensor = 1'b0;
        pat = 2'b00;
        build_frame(act_pix, hide_pix, act_line, hide_line, pat);
        push_idle(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({fval, lval, pix, fcnt} !== e) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d",
                         i, fval, lval, pix, fcnt, e.fval, e.lval, e.data, e.fcnt);
            end
            if (i == 0) enable = 1'b0;
        end
    endtask

    initial begin
        reset_sensor = 1'b1;
        enable = 1'b0;
        act_pix = '0; hide_pix = '0; act_line = '0; hide_line = '0; pat = 2'b00;
        model_reset();
        test_reset();
        test_basic_frame();
        test_random_frames();
        test_back_to_back();
        test_zero_regs();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sensor_stream_gen.md
SENSOR_STREAM_GEN -- requirements
Module: sensor_stream_gen

Interface
REQ-001 SHALL have parameter SENSOR_DAT_WIDTH, default 10, the per-channel pixel width in bits.
REQ-002 SHALL have parameter CHANNEL_NUM, default 4, the number of pixels per clock.
REQ-003 SHALL have parameter REG_WD, default 32, the width of every timing register input.
REQ-004 SHALL have parameter FVAL_LVAL_GAP, default 3, the clocks between fval edge and lval edge.
REQ-005 SHALL have port clk_sensor_pix, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset_sensor, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_stream_enable, input, 1 bit: acquisition run request.
REQ-008 SHALL have port iv_line_active_pix, input, REG_WD bits: active beats per line.
REQ-009 SHALL have port iv_line_hide_pix, input, REG_WD bits: horizontal blank beats.
REQ-010 SHALL have port iv_frame_active_line, input, REG_WD bits: lines per frame.
REQ-011 SHALL have port iv_frame_hide_line, input, REG_WD bits: vertical blank clocks.
REQ-012 SHALL have port iv_pattern_sel, input, 2 bits: test-pattern select.
REQ-013 SHALL have port o_fval, output, 1 bit: frame valid.
REQ-014 SHALL have port o_lval, output, 1 bit: line valid.
REQ-015 SHALL have port ov_pix_data, output, SENSOR_DAT_WIDTH*CHANNEL_NUM bits: pixel data; channel 0 in the LSBs.
REQ-016 SHALL have port ov_frame_cnt, output, 16 bits: completed-frame counter.

Function
REQ-017 SHALL implement states IDLE, LEAD, ACT, HIDE, TAIL, VBLANK.
REQ-018 In IDLE, i_stream_enable=1 SHALL move the block to LEAD and drive o_fval=1 on the next cycle, i.e. 1-clock latency.
REQ-019 LEAD SHALL last FVAL_LVAL_GAP clocks with o_fval=1 and o_lval=0, then move to ACT.
REQ-020 ACT SHALL last iv_line_active_pix clocks with o_lval=1.
REQ-021 After ACT, if the line is not the last line, the block SHALL move to HIDE for iv_line_hide_pix clocks with o_lval=0, then return to ACT.
REQ-022 After ACT on the last line, the block SHALL move directly to TAIL.
REQ-023 TAIL SHALL last FVAL_LVAL_GAP clocks with o_fval=1, then move to VBLANK.
REQ-024 VBLANK SHALL last iv_frame_hide_line clocks with o_fval=0.
REQ-025 At the end of VBLANK the block SHALL go to LEAD if i_stream_enable=1, else to IDLE.
REQ-026 All four timing registers and iv_pattern_sel SHALL be latched on entry to LEAD and held constant for the whole frame; mid-frame changes SHALL have no effect.
REQ-027 A latched value of 0 SHALL be treated as 1 for active pix and active lines, and as 1 for the hide counts.
REQ-028 Counters SHALL be REG_WD wide and SHALL never wrap within a frame.
REQ-029 Deasserting i_stream_enable mid-frame SHALL NOT truncate the frame; the frame SHALL complete through VBLANK and the block SHALL then enter IDLE.
REQ-030 ov_pix_data SHALL be 0 whenever o_lval=0.
REQ-031 While o_lval=1, ov_pix_data SHALL follow iv_pattern_sel:
  - 00: every channel = line index.
  - 01: every channel = ov_frame_cnt.
  - 10: channel c = beat_index*CHANNEL_NUM + c.
  - 11: see Configuration.
REQ-032 All pattern values SHALL be truncated to SENSOR_DAT_WIDTH bits.
REQ-033 ov_frame_cnt SHALL increment by 1 on each TAIL to VBLANK transition and SHALL wrap at 0xFFFF.
REQ-034 o_fval, o_lval and ov_pix_data SHALL all be registered, with no combinational path from inputs.

Reset
REQ-035 reset_sensor=1 SHALL force IDLE, o_fval=0, o_lval=0, ov_pix_data=0, ov_frame_cnt=0, all counters 0 and the LFSR to seed 0x1, on the next rising edge.
REQ-036 A reset asserted mid-frame SHALL abort the frame immediately; the first frame after release SHALL start fresh from LEAD.

Configuration
REQ-037 With SENSOR_STREAM_GEN_RANDOM_EN defined, pattern 11 SHALL drive each channel from a per-channel 16-bit Fibonacci LFSR (taps 16,14,13,11) advanced once per active beat, and the low SENSOR_DAT_WIDTH bits SHALL be output.
REQ-038 With SENSOR_STREAM_GEN_RANDOM_EN undefined, pattern 11 SHALL behave as 10, and no LFSR logic SHALL be synthesized.

Structure
REQ-039 The shared package sensor_stream_pkg SHALL hold the state encoding and the pattern-select constants PAT_LINE_INC, PAT_FRAME_INC, PAT_PIX_INC and PAT_RANDOM.
REQ-040 The pattern datapath SHALL be a single sub-module, sensor_pattern_gen.

Verification
REQ-041 Basic frame: enable=1, active_pix=8, hide_pix=4, lines=3, vblank=10 -> fval high 3+8*3+4*2+3=38 clocks; 3 lval pulses of 8 clocks each; lval rises exactly 3 clocks after fval rises.
REQ-042 Pattern 10 with CHANNEL_NUM=4 -> the first beat of every line is {3,2,1,0}, the second beat is {7,6,5,4}.
REQ-043 Disable mid-line -> the current frame completes to all 3 lines, then IDLE; ov_frame_cnt increments by exactly 1.
REQ-044 Change active_pix from 8 to 16 during line 2 -> the current frame keeps 8-beat lines; the next frame has 16-beat lines.
REQ-045 Zero registers (all four = 0) -> 1 line of 1 beat; fval high 3+1+3=7 clocks.
REQ-046 Reset during ACT -> the next cycle shows fval=0, lval=0, data=0, frame_cnt=0; after release with enable=1, fval rises 1 clock later.
